// File: rtl/debug_mem_writer_if.sv
// Debug write port into the MIPS data memory: single-word write request
// (wr_en/wr_addr/wr_data) answered by wr_ack from the memory side.
interface debug_mem_writer_if #(
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ack;

  // Writer side drives the request, memory side answers with ack
  modport master (output wr_en, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/debug_mem_writer.sv
// Operator-driven memory writer: debounced buttons key a 32-bit word in
// nibble by nibble, latch a word address and commit the word to data memory
// over a req/ack debug port with an ack timeout.
module debug_mem_writer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ADDR_W          = 6,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_digit,
  input  logic              btn_addr,
  input  logic              btn_commit,
  input  logic [3:0]        nibble_in,
  input  logic [ADDR_W-1:0] addr_in,
  debug_mem_writer_if.master mem,
  output logic [31:0]       entry,
  output logic [3:0]        digit_count,
  output logic              busy,
  output logic              err
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT);

  // Button index: 0 = digit, 1 = addr, 2 = commit
  logic [2:0] btn_raw;
  logic [2:0] pulse;
  assign btn_raw = {btn_commit, btn_addr, btn_digit};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_db
      logic            sync1_q, sync2_q;
      logic            level_q, level_d;
      logic            level_prev_q;
      logic [DB_W-1:0] cnt_q, cnt_d;

      // Count consecutive samples that disagree with the accepted level;
      // a full run of them flips the level, any agreement restarts the run
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = ~level_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Synchroniser, debounce state and previous level for edge detection
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q      <= btn_raw[gi];
          sync2_q      <= sync1_q;
          level_q      <= level_d;
          level_prev_q <= level_q;
          cnt_q        <= cnt_d;
        end
      end

      assign pulse[gi] = level_q & ~level_prev_q;
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_DONE    = 2'd2,
    S_WAITREL = 2'd3
  } state_t;

  state_t            state_q;
  logic [31:0]       entry_q;
  logic [3:0]        digit_count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              err_q;
  logic [TO_W-1:0]   to_cnt_q;

  // Entry/commit FSM; commit outranks addr which outranks digit, and the
  // losers of a same-cycle collision are simply dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      entry_q       <= '0;
      digit_count_q <= '0;
      addr_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pulse[2]) begin
            wr_addr_q <= addr_q;
            wr_data_q <= entry_q;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
            wr_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_WRITE;
          end else if (pulse[1]) begin
            addr_q <= addr_in;
          end else if (pulse[0]) begin
            entry_q <= {entry_q[27:0], nibble_in};
            if (digit_count_q != 4'd8) begin
              digit_count_q <= digit_count_q + 4'd1;
            end
          end
        end
        S_WRITE: begin
          if (mem.wr_ack) begin
            wr_en_q <= 1'b0;
            state_q <= S_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            wr_en_q <= 1'b0;
            state_q <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          entry_q       <= '0;
          digit_count_q <= '0;
          state_q       <= S_WAITREL;
        end
        S_WAITREL: begin
          // A held ack must drop before the next write may start
          if (!mem.wr_ack) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.wr_en   = wr_en_q;
  assign mem.wr_addr = wr_addr_q;
  assign mem.wr_data = wr_data_q;
  assign entry       = entry_q;
  assign digit_count = digit_count_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_debug_mem_writer.sv
// Self-checking bench for debug_mem_writer with short debounce/timeout
// parameters; the reference model keeps the entered nibbles in a queue.
module tb_debug_mem_writer;

  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic          btn_digit, btn_addr, btn_commit;
  logic [3:0]    nibble_in;
  logic [AW-1:0] addr_in;
  logic [31:0]   entry;
  logic [3:0]    digit_count;
  logic          busy, err;

  debug_mem_writer_if #(.ADDR_W(AW)) mem_if ();

  debug_mem_writer #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_W(AW),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_digit(btn_digit),
    .btn_addr(btn_addr),
    .btn_commit(btn_commit),
    .nibble_in(nibble_in),
    .addr_in(addr_in),
    .mem(mem_if),
    .entry(entry),
    .digit_count(digit_count),
    .busy(busy),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: up to the last 8 nibbles entered, plus latched state
  logic [3:0]    m_nibs[$];
  logic [AW-1:0] m_addr;

  function automatic logic [31:0] m_entry();
    logic [31:0] v = 32'h0;
    foreach (m_nibs[i]) v = v * 16 + 32'(m_nibs[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press_digit(input logic [3:0] nib);
    nibble_in = nib;
    btn_digit = 1'b1;
    repeat (10) @(negedge clk);
    btn_digit = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_addr(input logic [AW-1:0] a);
    addr_in  = a;
    btn_addr = 1'b1;
    repeat (10) @(negedge clk);
    btn_addr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Model-side effect of an accepted digit press
  task automatic model_digit(input logic [3:0] nib);
    m_nibs.push_back(nib);
    if (m_nibs.size() > 8) void'(m_nibs.pop_front());
  endtask

  // Press commit, check the request, count wr_en cycles; ack_at<0 = never ack
  task automatic commit_and_measure(input int ack_at, input bit with_digit,
                                    input logic [31:0] exp_data, output int en_cycles);
    int waited = 0;
    en_cycles  = 0;
    btn_commit = 1'b1;
    btn_digit  = with_digit;
    while (mem_if.wr_en !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("wr_en_rise", 32'(mem_if.wr_en), 32'h1);
    check("wr_addr", 32'(mem_if.wr_addr), 32'(m_addr));
    check("wr_data", mem_if.wr_data, exp_data);
    while (mem_if.wr_en === 1'b1 && en_cycles < 40) begin
      en_cycles++;
      if (ack_at >= 0 && en_cycles == ack_at + 1) mem_if.wr_ack = 1'b1;
      @(negedge clk);
    end
    btn_commit = 1'b0;
    btn_digit  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    int ack_at;
    logic [31:0] exp_data;
    logic [3:0]  nib;
    logic [3:0]  beef[8];
    beef = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};

    rst = 1'b1;
    btn_digit = 1'b0; btn_addr = 1'b0; btn_commit = 1'b0;
    nibble_in = 4'h0; addr_in = '0;
    mem_if.wr_ack = 1'b0;
    m_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(mem_if.wr_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_entry", entry, 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed digit entry 1..8, then a 9th digit shifts the oldest out
    for (int i = 1; i <= 9; i++) begin
      press_digit(4'(i));
      model_digit(4'(i));
      check("digit_entry", entry, m_entry());
      check("digit_count", 32'(digit_count), 32'(m_nibs.size()));
    end
    check("entry_9th", entry, 32'h23456789);

    // Bounce shorter than the debounce window must not register
    nibble_in = 4'hC;
    for (int i = 0; i < 10; i++) begin
      btn_digit = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_digit = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_entry", entry, m_entry());
    check("bounce_count", 32'(digit_count), 32'(m_nibs.size()));

    // Commit 0xDEADBEEF to 0x2A, ack three cycles after wr_en rises
    foreach (beef[i]) begin
      press_digit(beef[i]);
      model_digit(beef[i]);
    end
    check("beef_entry", entry, 32'hDEADBEEF);
    press_addr(6'h2A);
    m_addr = 6'h2A;
    exp_data = m_entry();
    commit_and_measure(3, 1'b0, exp_data, n);
    m_nibs.delete();
    check("ack_en_cycles", 32'(n), 32'd4);
    check("waitrel_busy", 32'(busy), 32'h1);
    mem_if.wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("ack_busy", 32'(busy), 32'h0);
    check("ack_entry", entry, 32'h0);
    check("ack_count", 32'(digit_count), 32'h0);
    check("ack_err", 32'(err), 32'h0);
    check("keep_wr_addr", 32'(mem_if.wr_addr), 32'h2A);
    check("keep_wr_data", mem_if.wr_data, 32'hDEADBEEF);

    // Random digits, then a commit that never sees ack -> timeout
    for (int i = 0; i < 5; i++) begin
      nib = 4'($urandom_range(0, 15));
      press_digit(nib);
      model_digit(nib);
      check("rand_entry", entry, m_entry());
      check("rand_count", 32'(digit_count), 32'(m_nibs.size()));
    end
    exp_data = m_entry();
    commit_and_measure(-1, 1'b0, exp_data, n);
    m_nibs.delete();
    check("to_en_cycles", 32'(n), 32'd9);
    check("to_err", 32'(err), 32'h1);
    check("to_busy", 32'(busy), 32'h0);

    // Random commits with random ack delay; the first also clears err
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        nib = 4'($urandom_range(0, 15));
        press_digit(nib);
        model_digit(nib);
      end
      m_addr = AW'($urandom_range(0, 63));
      press_addr(m_addr);
      ack_at = $urandom_range(0, 7);
      exp_data = m_entry();
      commit_and_measure(ack_at, 1'b0, exp_data, n);
      m_nibs.delete();
      check("rnd_en_cycles", 32'(n), 32'(ack_at + 1));
      mem_if.wr_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rnd_err", 32'(err), 32'h0);
      check("rnd_busy", 32'(busy), 32'h0);
    end

    // Addr and digit in the same cycle: addr wins, digit dropped
    press_digit(4'h5);
    model_digit(4'h5);
    nibble_in = 4'h9;
    addr_in   = 6'h15;
    btn_addr  = 1'b1;
    btn_digit = 1'b1;
    repeat (10) @(negedge clk);
    btn_addr  = 1'b0;
    btn_digit = 1'b0;
    repeat (10) @(negedge clk);
    m_addr = 6'h15;
    check("prio_ad_entry", entry, m_entry());
    check("prio_ad_count", 32'(digit_count), 32'(m_nibs.size()));

    // Commit and digit together with ack stuck high: one wr_en cycle
    mem_if.wr_ack = 1'b1;
    exp_data = m_entry();
    commit_and_measure(-1, 1'b1, exp_data, n);
    m_nibs.delete();
    check("held_en_cycles", 32'(n), 32'd1);
    check("held_busy", 32'(busy), 32'h1);
    press_digit(4'h7);
    check("busy_entry", entry, 32'h0);
    check("busy_count", 32'(digit_count), 32'h0);
    check("held_wr_en", 32'(mem_if.wr_en), 32'h0);
    mem_if.wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("held_rel_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a write
    for (int i = 0; i < 4; i++) begin
      nib = 4'($urandom_range(1, 15));
      press_digit(nib);
      model_digit(nib);
    end
    btn_commit = 1'b1;
    n = 0;
    while (mem_if.wr_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_wr_en", 32'(mem_if.wr_en), 32'h1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_wr_en", 32'(mem_if.wr_en), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_entry", entry, 32'h0);
    check("arst_wr_addr", 32'(mem_if.wr_addr), 32'h0);
    check("arst_wr_data", mem_if.wr_data, 32'h0);
    btn_commit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_mem_writer.md
Name: debug_mem_writer

Overview:
- Input-side counterpart of the 7-segment register/memory viewer.
- Lets the operator key a 32-bit word in nibble by nibble from the board switches, select a data-memory word address, and commit the write into the MIPS data memory over a debug write port with a req/ack handshake.
- Sits in the board top level between the switches/buttons and the CPU memory debug port.
- Exports the word under construction so the display can show it.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required before a button level is accepted (10 ms at 100 MHz).
- ADDR_W, 6, word-address width; matches the viewer's memory select.
- ACK_TIMEOUT, 255, maximum cycles to wait for wr_ack before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- btn_digit  in  1  raw push-button: shift nibble_in into entry
- btn_addr  in  1  raw push-button: latch addr_in
- btn_commit  in  1  raw push-button: start memory write
- nibble_in  in  4  hex digit from switches
- addr_in  in  ADDR_W  word address from switches
- wr_ack  in  1  memory accepted the write (may be held high)
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  write word address
- wr_data  out  32  write data
- entry  out  32  word under construction
- digit_count  out  4  nibbles entered, saturating at 8
- busy  out  1  high while state is not IDLE
- err  out  1  sticky: last commit timed out

Behaviour:
- Reset (async, immediate): all outputs 0; addr register 0; FSM IDLE; debouncer levels 0 and counters 0.
- Debounce, per button:
  - 2-FF synchroniser, then counter.
  - Counter clears whenever the synced sample equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level toggles and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle pulse.
  - Latency from a stable raw press to the pulse: DEBOUNCE_CYCLES+2 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Pulse priority within a single cycle: commit > addr > digit. Lower-priority pulses in the same cycle are dropped, not queued.
- In IDLE:
  - Digit pulse: entry <= {entry[27:0], nibble_in}; digit_count <= min(digit_count+1, 8). Once 8 digits are entered, further shifts still occur and the oldest nibble falls off.
  - Addr pulse: addr register <= addr_in.
  - Commit pulse: wr_addr <= addr register, wr_data <= entry, err <= 0, timeout counter <= 0, go to WRITE.
- Outside IDLE, all button pulses are ignored.
- FSM states:
  - IDLE: wr_en=0.
  - WRITE: wr_en=1; wr_addr and wr_data held stable.
    - If wr_ack=1 in a cycle, go to DONE.
    - Else if the timeout counter reaches ACK_TIMEOUT, set err=1 and go to DONE.
    - Else increment the timeout counter.
    - wr_en is first asserted the cycle after the commit pulse and is deasserted the cycle after wr_ack is sampled.
  - DONE (1 cycle): wr_en=0; entry <= 0; digit_count <= 0; go to WAITREL.
  - WAITREL: stay until wr_ack=0, then go to IDLE. This prevents a held ack from completing the next write.
- busy = (state != IDLE), registered alongside the state.
- wr_addr and wr_data retain their last committed values after the write.
- Reset mid-WRITE: wr_en drops immediately and no write is claimed.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8.
- Digit entry: press digit 8 times with nibble_in = 1,2,…,8 -> entry=0x12345678, digit_count=8. A 9th press with 0x9 -> entry=0x23456789, digit_count=8.
- Bounce rejection: btn_digit toggled every 2 cycles for 20 cycles, then released -> no pulse; entry unchanged.
- Commit with ack: addr_in=0x2A, addr press, entry=0xDEADBEEF, commit; ack asserted 3 cycles after wr_en rises -> wr_en high exactly 4 cycles with wr_addr=0x2A, wr_data=0xDEADBEEF; then entry=0, digit_count=0, err=0, busy back to 0 once ack drops.
- Timeout: commit with wr_ack tied 0 -> wr_en high 9 cycles, then err=1, busy=0. The next commit clears err.
- Held ack and priority: commit and digit pulses in the same cycle -> digit dropped. wr_ack stuck high -> exactly one 1-cycle wr_en, then FSM waits in WAITREL (busy=1) until ack is released. Digit presses during busy leave entry unchanged.
- Async reset asserted mid-WRITE -> wr_en, busy, entry, wr_addr, wr_data all 0 in the same cycle, without waiting for a clock edge.
